gb_instr_issuer: RTL and testbench

Upstream feeder stage for gbprocessor: accepts instruction bytes from a producer (bench driver or program ROM reader) over a valid/ready handshake and buffers them in a small FIFO. It drives the processor's instruction/valid pair with one-cycle valid pulses and configurable inter-instruction gaps. CB-prefixed opcodes are always issued as an atomic back-to-back pair. It also provides an issued-instruction counter for scoreboarding against probe.

---
 rtl/gb_pkg.sv | 14 +
 rtl/gb_instr_fifo.sv | 54 +++++
 rtl/gb_instr_issuer.sv | 130 +++++++++++++
 tb/tb_gb_instr_issuer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_pkg.sv
// Shared types and constants for the gbprocessor instruction issuer.
package gb_pkg;

    typedef logic [7:0] instr_t;

    localparam instr_t PREFIX_CB = 8'hCB;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREFIX = 2'd1,
        GAP    = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/gb_instr_fifo.sv
// Small synchronous byte FIFO with up to two pops per cycle and a two-entry
// peek, so the issuer can see a CB prefix and its operand together.
module gb_instr_fifo
    import gb_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  instr_t        din,
    input  logic [1:0]    pop_cnt,
    output instr_t        head,
    output instr_t        next,
    output logic [LW-1:0] level
);

    instr_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [LW-1:0] level_r;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clock) begin
        if (push && !clear) begin
            mem[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; the level counter separates full from empty.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else if (clear) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            rd_ptr_r <= rd_ptr_r + AW'(pop_cnt);
            wr_ptr_r <= wr_ptr_r + AW'(push);
            level_r  <= level_r + LW'(push) - LW'(pop_cnt);
        end
    end

    assign head  = mem[rd_ptr_r];
    assign next  = mem[rd_ptr_r + AW'(1)];
    assign level = level_r;

endmodule

// File: rtl/gb_instr_issuer.sv
// Feeds buffered instruction bytes to gbprocessor as one-cycle valid pulses,
// keeping CB-prefixed opcodes atomic and pacing issues with an optional gap.
module gb_instr_issuer
    import gb_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 0,
    parameter int CNT_W      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               in_instr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     hold,
    input  logic                     flush,
    output logic [7:0]               instruction,
    output logic                     valid,
    output logic [CNT_W-1:0]         issued_count,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int              LW      = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0]   DEPTH_L = LW'(DEPTH);
    localparam logic [3:0]      GAP_L   = 4'(GAP_CYCLES);

    issuer_state_t    state_r;
    instr_t           instruction_r;
    instr_t           operand_r;
    logic             valid_r;
    logic [3:0]       gap_cnt_r;
    logic [CNT_W-1:0] count_r;

    instr_t           head_s;
    instr_t           next_s;
    logic [LW-1:0]    level_s;
    logic             push_s;
    logic             head_is_cb_s;
    logic             start_s;
    logic [1:0]       pop_cnt_s;

    gb_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (flush),
        .push    (push_s),
        .din     (in_instr),
        .pop_cnt (pop_cnt_s),
        .head    (head_s),
        .next    (next_s),
        .level   (level_s)
    );

    assign in_ready     = reset && (level_s < DEPTH_L) && !flush;
    assign push_s       = in_valid && in_ready;
    assign head_is_cb_s = (head_s == PREFIX_CB);

    // A CB prefix only starts once its operand is already buffered behind it.
    assign start_s = (state_r == IDLE) && (level_s != '0) && !hold && !flush &&
                     (gap_cnt_r == 4'd0) && (!head_is_cb_s || (level_s >= LW'(2)));

    // Pop one byte for a plain opcode, both bytes of a CB pair at once.
    always_comb begin
        pop_cnt_s = 2'd0;
        if (start_s) begin
            pop_cnt_s = head_is_cb_s ? 2'd2 : 2'd1;
        end else begin
            pop_cnt_s = 2'd0;
        end
    end

    // Issue FSM; PREFIX always completes the pair regardless of hold or flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            instruction_r <= 8'h00;
            operand_r     <= 8'h00;
            valid_r       <= 1'b0;
            gap_cnt_r     <= 4'd0;
            count_r       <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        instruction_r <= head_s;
                        valid_r       <= 1'b1;
                        count_r       <= count_r + CNT_W'(1);
                        if (head_is_cb_s) begin
                            operand_r <= next_s;
                            state_r   <= PREFIX;
                        end else begin
                            gap_cnt_r <= GAP_L;
                            state_r   <= (GAP_L != 4'd0) ? GAP : IDLE;
                        end
                    end else begin
                        valid_r   <= 1'b0;
                        gap_cnt_r <= 4'd0;
                    end
                end
                PREFIX: begin
                    instruction_r <= operand_r;
                    valid_r       <= 1'b1;
                    count_r       <= count_r + CNT_W'(1);
                    gap_cnt_r     <= GAP_L;
                    state_r       <= (GAP_L != 4'd0) ? GAP : IDLE;
                end
                GAP: begin
                    valid_r <= 1'b0;
                    if (flush || (gap_cnt_r <= 4'd1)) begin
                        gap_cnt_r <= 4'd0;
                        state_r   <= IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - 4'd1;
                    end
                end
                default: begin
                    valid_r   <= 1'b0;
                    gap_cnt_r <= 4'd0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign instruction  = instruction_r;
    assign valid        = valid_r;
    assign issued_count = count_r;
    assign fifo_level   = level_s;

endmodule

// File: tb/tb_gb_instr_issuer.sv
// Scoreboard bench for gb_instr_issuer: one instance without gap (4-bit
// counter for the wrap test) and one with GAP_CYCLES=2.
module tb_gb_instr_issuer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] in_instr;
    logic       in_valid, in_ready, hold, flush, valid;
    logic [7:0] instruction;
    logic [3:0] issued_count;
    logic [3:0] fifo_level;

    logic [7:0]  g_in_instr;
    logic        g_in_valid, g_in_ready, g_hold, g_flush, g_valid;
    logic [7:0]  g_instruction;
    logic [15:0] g_issued_count;
    logic [3:0]  g_fifo_level;

    gb_instr_issuer #(.DEPTH(8), .GAP_CYCLES(0), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .in_instr(in_instr), .in_valid(in_valid),
        .in_ready(in_ready), .hold(hold), .flush(flush), .instruction(instruction),
        .valid(valid), .issued_count(issued_count), .fifo_level(fifo_level)
    );

    gb_instr_issuer #(.DEPTH(8), .GAP_CYCLES(2), .CNT_W(16)) dut_gap (
        .clock(clock), .reset(reset), .in_instr(g_in_instr), .in_valid(g_in_valid),
        .in_ready(g_in_ready), .hold(g_hold), .flush(g_flush), .instruction(g_instruction),
        .valid(g_valid), .issued_count(g_issued_count), .fifo_level(g_fifo_level)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_t[$];
    logic [7:0] g_exp_q[$];
    logic [7:0] g_obs_q[$];
    int         g_obs_t[$];

    int checks  = 0;
    int errors  = 0;
    int exp_cnt = 0;
    int g_exp_cnt = 0;
    int last_push = 0;

    // Monitors: record every issued byte with the cycle it appeared in.
    always @(negedge clock) begin
        if (valid === 1'b1) begin
            obs_q.push_back(instruction);
            obs_t.push_back(cyc);
        end
        if (g_valid === 1'b1) begin
            g_obs_q.push_back(g_instruction);
            g_obs_t.push_back(cyc);
        end
    end

    task automatic push_main(input logic [7:0] b);
        int n;
        n = 0;
        in_instr = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL push_timeout got in_ready=%b want 1", in_ready);
        end else begin
            @(posedge clock); #1;
            exp_q.push_back(b);
            last_push = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic push_gap(input logic [7:0] b);
        int n;
        n = 0;
        g_in_instr = b;
        g_in_valid = 1'b1;
        while (!g_in_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
        checks++;
        if (!g_in_ready) begin
            errors++;
            $display("FAIL gpush_timeout got in_ready=%b want 1", g_in_ready);
        end else begin
            @(posedge clock); #1;
            g_exp_q.push_back(b);
            last_push = cyc;
        end
        g_in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #7;
        checks += 5;
        if (valid !== 1'b0)       begin errors++; $display("FAIL rst_valid got %b want 0", valid); end
        if (instruction !== 8'h00) begin errors++; $display("FAIL rst_instr got %h want 00", instruction); end
        if (in_ready !== 1'b0)    begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (issued_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", issued_count); end
        if (fifo_level !== 4'd0)  begin errors++; $display("FAIL rst_level got %0d want 0", fifo_level); end
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_basic;
        int k0;
        logic [7:0] e, o;
        push_main(8'h80);
        k0 = last_push;
        push_main(8'h3C);
        push_main(8'h05);
        idle(5);
        checks++;
        if (obs_q.size() != 3) begin
            errors++; $display("FAIL basic_count got %0d want 3", obs_q.size());
        end else begin
            checks += 3;
            if (obs_t[0] != k0 + 1) begin errors++; $display("FAIL basic_latency got %0d want %0d", obs_t[0], k0 + 1); end
            if (obs_t[1] != k0 + 2) begin errors++; $display("FAIL basic_t1 got %0d want %0d", obs_t[1], k0 + 2); end
            if (obs_t[2] != k0 + 3) begin errors++; $display("FAIL basic_t2 got %0d want %0d", obs_t[2], k0 + 3); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_cnt = (exp_cnt + 1) % 16;
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL basic_missing got none want %h", e); end
            else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) begin errors++; $display("FAIL basic_byte got %h want %h", o, e); end
            end
        end
        checks++;
        if (issued_count !== 4'(exp_cnt)) begin errors++; $display("FAIL basic_issued got %0d want %0d", issued_count, exp_cnt); end
        obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_backpressure;
        logic [7:0] e, o;
        hold = 1'b1;
        for (int i = 0; i < 8; i++) push_main(8'h10 + 8'(i));
        checks += 2;
        if (in_ready !== 1'b0)    begin errors++; $display("FAIL bp_ready got %b want 0", in_ready); end
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL bp_level got %0d want 8", fifo_level); end
        in_instr = 8'h18;
        in_valid = 1'b1;
        idle(3);
        checks += 2;
        if (fifo_level !== 4'd8) begin errors++; $display("FAIL bp_level_held got %0d want 8", fifo_level); end
        if (obs_q.size() != 0)   begin errors++; $display("FAIL bp_hold_issue got %0d want 0", obs_q.size()); end
        hold = 1'b0;
        push_main(8'h18);
        idle(15);
        checks++;
        if (obs_q.size() != 9) begin errors++; $display("FAIL bp_count got %0d want 9", obs_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_cnt = (exp_cnt + 1) % 16;
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL bp_missing got none want %h", e); end
            else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) begin errors++; $display("FAIL bp_byte got %h want %h", o, e); end
            end
        end
        checks++;
        if (issued_count !== 4'(exp_cnt)) begin errors++; $display("FAIL bp_issued got %0d want %0d", issued_count, exp_cnt); end
        obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_cb_pair;
        logic [7:0] e, o;
        push_main(8'hCB);
        idle(5);
        checks += 2;
        if (obs_q.size() != 0)   begin errors++; $display("FAIL cb_lonely got %0d pulses want 0", obs_q.size()); end
        if (fifo_level !== 4'd1) begin errors++; $display("FAIL cb_lonely_level got %0d want 1", fifo_level); end
        push_main(8'h37);
        idle(1);
        hold = 1'b1;
        push_main(8'h44);
        idle(3);
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL cb_hold_pair got %0d want 2", obs_q.size()); end
        push_main(8'hCB);
        push_main(8'h37);
        hold = 1'b0;
        idle(1);
        hold = 1'b1;
        idle(4);
        hold = 1'b0;
        idle(4);
        checks++;
        if (obs_q.size() != 5) begin
            errors++; $display("FAIL cb_count got %0d want 5", obs_q.size());
        end else begin
            checks += 2;
            if (obs_t[1] != obs_t[0] + 1) begin errors++; $display("FAIL cb_adjacent got %0d want %0d", obs_t[1], obs_t[0] + 1); end
            if (obs_t[4] != obs_t[3] + 1) begin errors++; $display("FAIL cb_hold_adjacent got %0d want %0d", obs_t[4], obs_t[3] + 1); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_cnt = (exp_cnt + 1) % 16;
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL cb_missing got none want %h", e); end
            else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) begin errors++; $display("FAIL cb_byte got %h want %h", o, e); end
            end
        end
        obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_flush;
        logic [7:0] e, o;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push_main(8'hA0 + 8'(i));
        flush = 1'b1;
        hold  = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
        @(posedge clock); #1;
        flush = 1'b0;
        exp_q.delete();
        checks++;
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL flush_level got %0d want 0", fifo_level); end
        idle(5);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL flush_issue got %0d want 0", obs_q.size()); end
        push_main(8'hCB);
        push_main(8'h37);
        push_main(8'h55);
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        checks++;
        if (fifo_level !== 4'd0) begin errors++; $display("FAIL flush_pfx_level got %0d want 0", fifo_level); end
        idle(5);
        checks++;
        if (obs_q.size() != 2) begin
            errors++; $display("FAIL flush_pfx_count got %0d want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_t[1] != obs_t[0] + 1) begin errors++; $display("FAIL flush_pfx_adjacent got %0d want %0d", obs_t[1], obs_t[0] + 1); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_cnt = (exp_cnt + 1) % 16;
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL flush_missing got none want %h", e); end
            else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) begin errors++; $display("FAIL flush_byte got %h want %h", o, e); end
            end
        end
        checks++;
        if (issued_count !== 4'(exp_cnt)) begin errors++; $display("FAIL flush_issued got %0d want %0d", issued_count, exp_cnt); end
        obs_q.delete(); obs_t.delete();
    endtask

    task automatic test_gap;
        logic [7:0] e, o;
        push_gap(8'h01);
        push_gap(8'h02);
        idle(8);
        push_gap(8'hCB);
        push_gap(8'h11);
        push_gap(8'h22);
        idle(10);
        checks++;
        if (g_obs_q.size() != 5) begin
            errors++; $display("FAIL gap_count got %0d want 5", g_obs_q.size());
        end else begin
            checks += 3;
            if (g_obs_t[1] != g_obs_t[0] + 3) begin errors++; $display("FAIL gap_spacing got %0d want %0d", g_obs_t[1], g_obs_t[0] + 3); end
            if (g_obs_t[3] != g_obs_t[2] + 1) begin errors++; $display("FAIL gap_pair got %0d want %0d", g_obs_t[3], g_obs_t[2] + 1); end
            if (g_obs_t[4] != g_obs_t[3] + 3) begin errors++; $display("FAIL gap_after_pair got %0d want %0d", g_obs_t[4], g_obs_t[3] + 3); end
        end
        while (g_exp_q.size() > 0) begin
            e = g_exp_q.pop_front();
            g_exp_cnt++;
            checks++;
            if (g_obs_q.size() == 0) begin errors++; $display("FAIL gap_missing got none want %h", e); end
            else begin
                o = g_obs_q.pop_front(); void'(g_obs_t.pop_front());
                if (o !== e) begin errors++; $display("FAIL gap_byte got %h want %h", o, e); end
            end
        end
        checks++;
        if (g_issued_count !== 16'(g_exp_cnt)) begin errors++; $display("FAIL gap_issued got %0d want %0d", g_issued_count, g_exp_cnt); end
    endtask

    task automatic test_reset_wrap;
        logic [7:0] e, o;
        hold = 1'b1;
        push_main(8'hB0);
        push_main(8'hB1);
        push_main(8'hB2);
        hold = 1'b0;
        idle(1);
        #2;
        reset = 1'b0;
        #1;
        checks += 4;
        if (valid !== 1'b0)        begin errors++; $display("FAIL mid_rst_valid got %b want 0", valid); end
        if (instruction !== 8'h00) begin errors++; $display("FAIL mid_rst_instr got %h want 00", instruction); end
        if (fifo_level !== 4'd0)   begin errors++; $display("FAIL mid_rst_level got %0d want 0", fifo_level); end
        if (in_ready !== 1'b0)     begin errors++; $display("FAIL mid_rst_ready got %b want 0", in_ready); end
        @(negedge clock);
        reset = 1'b1;
        idle(1);
        exp_q.delete(); obs_q.delete(); obs_t.delete();
        exp_cnt = 0;
        for (int i = 0; i < 17; i++) push_main(8'h60 + 8'(i));
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_cnt = (exp_cnt + 1) % 16;
            checks++;
            if (obs_q.size() == 0) begin errors++; $display("FAIL wrap_missing got none want %h", e); end
            else begin
                o = obs_q.pop_front(); void'(obs_t.pop_front());
                if (o !== e) begin errors++; $display("FAIL wrap_byte got %h want %h", o, e); end
            end
        end
        checks++;
        if (issued_count !== 4'(exp_cnt)) begin errors++; $display("FAIL wrap_issued got %0d want %0d", issued_count, exp_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        in_instr = 8'h00; in_valid = 1'b0; hold = 1'b0; flush = 1'b0;
        g_in_instr = 8'h00; g_in_valid = 1'b0; g_hold = 1'b0; g_flush = 1'b0;
        test_reset;
        test_basic;
        test_backpressure;
        test_cb_pair;
        test_flush;
        test_gap;
        test_reset_wrap;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
